decode_arb: RTL

DECODE_ARB -- requirements
Module: decode_arb

---
 rtl/decode_arb_pkg.sv | 21 ++
 rtl/decode_arb_rr_arbiter.sv | 32 +++
 rtl/decode_arb.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/decode_arb_pkg.sv
// rtl/decode_arb_pkg.sv - shared types and default constants for decode_arb
// Contents: FSM state enum, default parameter values, pointer wrap helper.
package decode_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int NREQ_DEF   = 4;
    localparam int IN_W_DEF   = 25;
    localparam int OUT_W_DEF  = 39;
    localparam int SETTLE_DEF = 2;

    // Round-robin successor of index v in a ring of n entries.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/decode_arb_rr_arbiter.sv
// rtl/decode_arb_rr_arbiter.sv - round-robin arbiter, one-hot grant
// Ports:
//   req   - request bits, one per requester
//   ptr   - highest-priority index; search runs ptr, ptr+1, ... wrapping
//   grant - one-hot grant to the first set req bit at or after ptr (zero if none)
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_arb.sv
// rtl/decode_arb.sv - round-robin sharing of one external combinational decoder
// Optional feature macro: DECODE_ARB_PARITY_EN (adds rsp_par = XOR of rsp_data).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/req_ready - per-requester handshake, req_vec holds NREQ packed vectors
//   dec_in/dec_out      - registered decoder input, decoder result
//   rsp_valid/rsp_ready - response handshake with rsp_data, rsp_id (and rsp_par)
module decode_arb
    import decode_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int IN_W   = IN_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*IN_W-1:0]     req_vec,
    output logic [IN_W-1:0]          dec_in,
    input  logic [OUT_W-1:0]         dec_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [OUT_W-1:0]         rsp_data,
`ifdef DECODE_ARB_PARITY_EN
    output logic                     rsp_par,
`endif
    output logic [$clog2(NREQ)-1:0]  rsp_id
);

    localparam int ID_W = $clog2(NREQ);

    state_e            state_q, state_d;
    logic              armed_q;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [3:0]        settle_q, settle_d;
    logic [IN_W-1:0]   dec_in_q, dec_in_d;
    logic [OUT_W-1:0]  rsp_data_q, rsp_data_d;

    logic [ID_W-1:0]   ptr_nxt;
    logic [ID_W-1:0]   arb_ptr;
    logic [ID_W-1:0]   grant_id;
    logic [NREQ-1:0]   grant;
    logic              can_grant;
    logic              req_fire;
    logic              rsp_fire;
    logic              capture;

    // Pointer the arbiter will hold once the current response retires.
    assign ptr_nxt = ID_W'(wrap_inc(int'(rsp_id_q), NREQ));

    // While a response retires in HOLD the next grant is issued in the same
    // cycle, so the arbiter already uses the post-retire pointer there.
    assign arb_ptr = (state_q == HOLD) ? ptr_nxt : rr_ptr_q;

    rr_arbiter #(
        .N     (NREQ),
        .PTR_W (ID_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (arb_ptr),
        .grant (grant)
    );

    // armed_q keeps req_ready low until the first edge after reset release.
    assign can_grant = armed_q &&
                       ((state_q == IDLE) || ((state_q == HOLD) && rsp_ready));
    assign req_ready = can_grant ? grant : '0;
    assign req_fire  = |(req_valid & req_ready);
    assign rsp_valid = (state_q == HOLD);
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign capture   = (state_q == EVAL) && (settle_q == 4'd0);

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_id = ID_W'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_id_d   = rsp_id_q;
        settle_d   = settle_q;
        dec_in_d   = dec_in_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: ;
            EVAL: begin
                if (settle_q == 4'd0) begin
                    rsp_data_d = dec_out;
                    state_d    = HOLD;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            HOLD: begin
                if (rsp_fire) begin
                    rr_ptr_d = ptr_nxt;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // req_fire is only possible in IDLE or in a retiring HOLD.
        if (req_fire) begin
            dec_in_d = req_vec[grant_id*IN_W +: IN_W];
            rsp_id_d = grant_id;
            settle_d = 4'(SETTLE - 1);
            state_d  = EVAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            rr_ptr_q   <= '0;
            rsp_id_q   <= '0;
            settle_q   <= '0;
            dec_in_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= 1'b1;
            rr_ptr_q   <= rr_ptr_d;
            rsp_id_q   <= rsp_id_d;
            settle_q   <= settle_d;
            dec_in_q   <= dec_in_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign dec_in   = dec_in_q;
    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;

`ifdef DECODE_ARB_PARITY_EN
    logic rsp_par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_par_q <= 1'b0;
        end else if (capture) begin
            rsp_par_q <= ^dec_out;
        end
    end

    assign rsp_par = rsp_par_q;
`endif

endmodule
